modexp_seq: RTL and testbench

//  Sequential, parametrised modular exponentiation: result = base^exponent mod modulus.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/modmul_seq.sv | 70 +++++++
 rtl/modexp_seq.sv | 191 +++++++++++++++++++
 tb/tb_modexp_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and default sizes for the sequential modular exponentiator.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    SQR  = 3'd3,
    FIN  = 3'd4
  } modexp_state_t;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_EXP_WIDTH = 32;

endpackage

// File: rtl/modmul_seq.sv
// Sequential interleaved shift-add modular multiplier: p = a*b mod m, one
// multiplier bit per cycle, MSB first. Inputs must satisfy a, b < m.
module modmul_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] red1;
  logic [WIDTH+1:0] red2;
  logic [CW-1:0]    cnt;
  logic             running;

  // One iteration: 2p + (a_i ? b : 0) stays below 3m, so two conditional subtracts suffice.
  always_comb begin
    m_ext = {2'b00, m_q};
    sum   = (acc << 1) + (a_sh[WIDTH-1] ? {2'b00, b_q} : {(WIDTH+2){1'b0}});
    red1  = (sum >= m_ext) ? (sum - m_ext) : sum;
    red2  = (red1 >= m_ext) ? (red1 - m_ext) : red1;
  end

  // Capture operands on start, then iterate WIDTH times and pulse done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_sh    <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      m_q     <= {WIDTH{1'b0}};
      acc     <= {(WIDTH+2){1'b0}};
      cnt     <= {CW{1'b0}};
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start && !running) begin
      a_sh    <= a;
      b_q     <= b;
      m_q     <= m;
      acc     <= {(WIDTH+2){1'b0}};
      cnt     <= CW'(WIDTH);
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      acc     <= red2;
      a_sh    <= a_sh << 1;
      cnt     <= cnt - CW'(1);
      running <= (cnt != CW'(1));
      done    <= (cnt == CW'(1));
    end else begin
      done    <= 1'b0;
    end
  end

  assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/modexp_seq.sv
// Constant-time right-to-left square-and-multiply modular exponentiation
// built around a single time-shared sequential modular multiplier.
module modexp_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result
);

  localparam int BW = $clog2(EXP_WIDTH + 1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  modexp_state_t state;
  modexp_state_t state_next;

  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     acc;
  logic [EXP_WIDTH-1:0] e_q;
  logic [BW-1:0]        bitcnt;
  logic                 op_err;

  logic                 accept;
  logic                 load_err;
  logic                 last_bit;
  logic [WIDTH-1:0]     acc_init;

  logic                 mm_start;
  logic                 mm_done;
  logic [WIDTH-1:0]     mm_a;
  logic [WIDTH-1:0]     mm_b;
  logic [WIDTH-1:0]     mm_p;

  // The done cycle still counts as busy, so a new request is taken one cycle later.
  assign accept   = (state == IDLE) && start && !busy;
  assign load_err = (m_q == ZERO) || (b_q >= m_q);
  assign acc_init = (m_q == ONE) ? ZERO : ONE;
  assign last_bit = (bitcnt == BW'(EXP_WIDTH - 1));

  modmul_seq #(.WIDTH(WIDTH)) u_modmul (
    .Clk   (Clk),
    .Reset (Reset),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (m_q),
    .done  (mm_done),
    .p     (mm_p)
  );

  // Next-state logic; each multiply is launched in the cycle that finishes the previous
  // one, feeding fresh results straight in, so every MUL/SQR phase is WIDTH+1 cycles.
  always_comb begin
    state_next = state;
    mm_start   = 1'b0;
    mm_a       = acc;
    mm_b       = b_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (load_err) begin
          state_next = FIN;
        end else begin
          state_next = MUL;
          mm_start   = 1'b1;
          mm_a       = acc_init;
          mm_b       = b_q;
        end
      end
      MUL: begin
        if (mm_done) begin
          state_next = SQR;
          mm_start   = 1'b1;
          mm_a       = b_q;
          mm_b       = b_q;
        end else begin
          state_next = MUL;
        end
      end
      SQR: begin
        if (mm_done && last_bit) begin
          state_next = FIN;
        end else if (mm_done) begin
          state_next = MUL;
          mm_start   = 1'b1;
          mm_a       = acc;
          mm_b       = mm_p;
        end else begin
          state_next = SQR;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture and exponentiation datapath.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      m_q    <= ZERO;
      b_q    <= ZERO;
      acc    <= ZERO;
      e_q    <= {EXP_WIDTH{1'b0}};
      bitcnt <= {BW{1'b0}};
      op_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m_q    <= modulus;
            b_q    <= base;
            e_q    <= exponent;
            op_err <= 1'b0;
          end
        end
        LOAD: begin
          bitcnt <= {BW{1'b0}};
          op_err <= load_err;
          acc    <= load_err ? ZERO : acc_init;
        end
        MUL: begin
          if (mm_done && e_q[0]) begin
            acc <= mm_p;
          end
        end
        SQR: begin
          if (mm_done) begin
            b_q    <= mm_p;
            e_q    <= e_q >> 1;
            bitcnt <= bitcnt + BW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= ZERO;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        result <= acc;
        err    <= op_err;
      end
      if (accept) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modexp_seq.sv
// Self-checking bench for modexp_seq: directed cases on 16- and 32-bit
// instances, random vectors on a small instance, against an arithmetic model.
module tb_modexp_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  start_s = 3'b000;
  logic [31:0] base_s = 32'd0;
  logic [31:0] exp_s = 32'd0;
  logic [31:0] mod_s = 32'd0;

  logic        busy16, done16, err16;
  logic [15:0] res16;
  logic        busy32, done32, err32;
  logic [31:0] res32;
  logic        busy6, done6, err6;
  logic [5:0]  res6;

  int n_checks = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  modexp_seq #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .start(start_s[0]),
    .base(base_s[15:0]), .exponent(exp_s[15:0]), .modulus(mod_s[15:0]),
    .busy(busy16), .done(done16), .err(err16), .result(res16));

  modexp_seq #(.WIDTH(32), .EXP_WIDTH(32)) dut32 (
    .Clk(Clk), .Reset(Reset), .start(start_s[1]),
    .base(base_s), .exponent(exp_s), .modulus(mod_s),
    .busy(busy32), .done(done32), .err(err32), .result(res32));

  modexp_seq #(.WIDTH(6), .EXP_WIDTH(3)) dut6 (
    .Clk(Clk), .Reset(Reset), .start(start_s[2]),
    .base(base_s[5:0]), .exponent(exp_s[2:0]), .modulus(mod_s[5:0]),
    .busy(busy6), .done(done6), .err(err6), .result(res6));

  function automatic logic get_done(input logic [1:0] sel);
    case (sel)
      2'd0:    return done16;
      2'd1:    return done32;
      default: return done6;
    endcase
  endfunction

  function automatic logic get_busy(input logic [1:0] sel);
    case (sel)
      2'd0:    return busy16;
      2'd1:    return busy32;
      default: return busy6;
    endcase
  endfunction

  function automatic logic get_err(input logic [1:0] sel);
    case (sel)
      2'd0:    return err16;
      2'd1:    return err32;
      default: return err6;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input logic [1:0] sel);
    case (sel)
      2'd0:    return {16'd0, res16};
      2'd1:    return res32;
      default: return {26'd0, res6};
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] sel, input logic is_err);
    int w, e;
    case (sel)
      2'd0:    begin w = 16; e = 16; end
      2'd1:    begin w = 32; e = 32; end
      default: begin w = 6;  e = 3;  end
    endcase
    return is_err ? 2 : 2 + 2 * e * (w + 1);
  endfunction

  // Reference: repeated multiplication, no bit-serial structure.
  function automatic void model(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                                output logic [31:0] r, output logic er);
    longint unsigned acc, bb, mm;
    bb = {32'd0, b};
    mm = {32'd0, m};
    if (mm == 64'd0 || bb >= mm) begin
      r = 32'd0;
      er = 1'b1;
    end else begin
      acc = 64'd1 % mm;
      for (longint unsigned i = 0; i < {32'd0, e}; i++) acc = (acc * bb) % mm;
      r = acc[31:0];
      er = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Runs one operation; poke_at >= 0 pulses start with other operands while busy.
  task automatic do_op(input logic [1:0] sel, input logic [31:0] b, input logic [31:0] e,
                       input logic [31:0] m, input int poke_at, input string tag);
    logic [31:0] exp_r;
    logic exp_err;
    int lat;
    model(b, e, m, exp_r, exp_err);
    @(negedge Clk);
    base_s = b; exp_s = e; mod_s = m; start_s[sel] = 1'b1;
    @(posedge Clk); #1;
    start_s[sel] = 1'b0;
    check({tag, " busy_after_accept"}, 64'(get_busy(sel)), 64'd1);
    lat = 0;
    while (!get_done(sel) && lat < 5000) begin
      if (lat == poke_at) begin
        base_s = 32'd3; exp_s = 32'd5; mod_s = 32'd11; start_s[sel] = 1'b1;
      end
      @(posedge Clk); #1;
      start_s[sel] = 1'b0;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(sel, exp_err)));
    check({tag, " result"}, 64'(get_res(sel)), 64'(exp_r));
    check({tag, " err"}, 64'(get_err(sel)), 64'(exp_err));
    check({tag, " busy_in_done"}, 64'(get_busy(sel)), 64'd1);
    @(posedge Clk); #1;
    check({tag, " done_pulse"}, 64'(get_done(sel)), 64'd0);
    check({tag, " busy_cleared"}, 64'(get_busy(sel)), 64'd0);
  endtask

  initial begin
    logic [31:0] rm, rb, re;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("reset busy16", 64'(busy16), 64'd0);
    check("reset done16", 64'(done16), 64'd0);
    check("reset err16", 64'(err16), 64'd0);
    check("reset res32", 64'(res32), 64'd0);

    do_op(2'd0, 32'd4, 32'd13, 32'd497, -1, "w16 4^13%497");
    check("w16 literal 445", 64'(res16), 64'd445);
    do_op(2'd1, 32'd65, 32'd17, 32'd3233, -1, "rsa enc");
    check("rsa enc literal", 64'(res32), 64'd2790);
    do_op(2'd1, 32'd2790, 32'd2753, 32'd3233, -1, "rsa dec");
    check("rsa dec literal", 64'(res32), 64'd65);

    do_op(2'd0, 32'd3, 32'd0, 32'd7, -1, "exp0");
    do_op(2'd0, 32'd0, 32'd9, 32'd1, -1, "mod1");
    do_op(2'd0, 32'd2, 32'd10, 32'd1000, -1, "2^10%1000");
    do_op(2'd0, 32'd5, 32'd3, 32'd0, -1, "mod0 err");
    do_op(2'd0, 32'd500, 32'd3, 32'd497, -1, "base>=mod err");
    do_op(2'd0, 32'd4, 32'd13, 32'd497, 40, "start while busy");

    // Abort mid-run at cycle 100, then verify a fresh operation.
    @(negedge Clk);
    base_s = 32'd4; exp_s = 32'd13; mod_s = 32'd497; start_s[0] = 1'b1;
    @(posedge Clk); #1;
    start_s[0] = 1'b0;
    repeat (99) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("midrun reset busy", 64'(busy16), 64'd0);
    check("midrun reset done", 64'(done16), 64'd0);
    check("midrun reset result", 64'(res16), 64'd0);
    do_op(2'd0, 32'd2, 32'd10, 32'd1000, -1, "after reset");

    for (int i = 0; i < 1000; i++) begin
      rm = $urandom_range(63, 0);
      rb = $urandom_range(rm, 0);
      re = $urandom_range(7, 0);
      do_op(2'd2, rb, re, rm, -1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
